// File: rtl/data_memory.sv
// Word-addressed WIDTH x DEPTH data memory: combinational read, write commits on rising clock.
// Zero-cycle read latency, one-edge write latency; no handshake, never stalls.
module data_memory #(
   parameter int WIDTH     = 32,
   parameter int DEPTH     = 1024,
   parameter int ADDR_BITS = 10
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [31:0]      address,
   input  logic             writeEnabled,
   input  logic [WIDTH-1:0] writeInput,
   output logic [WIDTH-1:0] readResult
);

   logic [WIDTH-1:0]     data [0:DEPTH-1];
   logic [ADDR_BITS-1:0] idx;
   logic                 unused_addr_hi;

   // Upper address bits are deliberately dropped so out-of-range indices wrap modulo DEPTH.
   assign idx            = address[ADDR_BITS-1:0];
   assign unused_addr_hi = ^address[31:ADDR_BITS];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            data[i] <= '0;
         end
      end else if (writeEnabled) begin
         data[idx] <= writeInput;
      end
   end

   assign readResult = data[idx];

endmodule

// File: tb/tb_data_memory.sv
// Directed and randomized checks of data_memory against a shadow word array.
module tb_data_memory;

   logic        clock;
   logic        reset;
   logic [31:0] address;
   logic        writeEnabled;
   logic [31:0] writeInput;
   logic [31:0] readResult;

   logic [31:0] model [0:1023];
   int          checks;
   int          errors;
   logic [31:0] hier_word;

   data_memory #(.WIDTH(32), .DEPTH(1024), .ADDR_BITS(10)) dut (
      .clock        (clock),
      .reset        (reset),
      .address      (address),
      .writeEnabled (writeEnabled),
      .writeInput   (writeInput),
      .readResult   (readResult)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 1024; i++) model[i] = 32'h0;
   endtask

   // One write committed at the next rising edge; inputs change on the falling edge.
   task automatic do_write(input logic [31:0] addr, input logic [31:0] value);
      @(negedge clock);
      address      = addr;
      writeInput   = value;
      writeEnabled = 1'b1;
      @(posedge clock);
      #1;
      writeEnabled = 1'b0;
      model[addr % 1024] = value;
   endtask

   task automatic read_check(input string tag, input logic [31:0] addr);
      address = addr;
      #1;
      hier_word = dut.data[addr % 1024];
      check(tag, readResult, model[addr % 1024]);
      check({tag, "_hier"}, hier_word, model[addr % 1024]);
   endtask

   initial begin
      int          op_is_write;
      logic [31:0] raddr;
      logic [31:0] rval;
      logic [31:0] written [$];

      checks       = 0;
      errors       = 0;
      reset        = 1'b0;
      address      = 32'd0;
      writeEnabled = 1'b0;
      writeInput   = 32'h0;
      model_clear();

      // Reset state
      #12;
      check("in_reset_read", readResult, 32'h0);
      reset = 1'b1;
      read_check("rst_a0", 32'd0);
      read_check("rst_a1", 32'd1);
      read_check("rst_a511", 32'd511);
      read_check("rst_a1023", 32'd1023);

      // Basic write then combinational read with no further edge
      do_write(32'd5, 32'hDEADBEEF);
      read_check("wr_a5", 32'd5);

      // Wrap: 1024+7 lands on word 7
      do_write(32'd1031, 32'h12345678);
      hier_word = dut.data[7];
      check("wrap_hier7", hier_word, 32'h12345678);
      read_check("wrap_a7", 32'd7);
      read_check("wrap_a1031", 32'd1031);

      // Write disable across several edges
      @(negedge clock);
      address      = 32'd9;
      writeInput   = 32'hFFFFFFFF;
      writeEnabled = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      read_check("wdis_a9", 32'd9);

      // Read-during-write: old word before the edge, new word right after
      @(negedge clock);
      address      = 32'd5;
      writeInput   = 32'hCAFEF00D;
      writeEnabled = 1'b1;
      #1;
      check("rdw_before", readResult, 32'hDEADBEEF);
      @(posedge clock);
      #1;
      writeEnabled = 1'b0;
      check("rdw_after", readResult, 32'hCAFEF00D);
      model[5] = 32'hCAFEF00D;

      // Back-to-back writes to one address: last edge wins
      do_write(32'd20, 32'h11111111);
      do_write(32'd20, 32'h22222222);
      read_check("b2b_a20", 32'd20);

      // Async reset between edges drops contents and a pending write
      do_write(32'd3, 32'h33333333);
      do_write(32'd4, 32'h44444444);
      read_check("pre_rst_a3", 32'd3);
      @(negedge clock);
      #2;
      address = 32'd3;
      reset   = 1'b0;
      #1;
      check("async_rst_a3", readResult, 32'h0);
      hier_word = dut.data[4];
      check("async_rst_hier4", hier_word, 32'h0);
      writeEnabled = 1'b1;
      writeInput   = 32'hAAAAAAAA;
      @(posedge clock);
      #1;
      hier_word = dut.data[3];
      check("rst_drop_write", hier_word, 32'h0);
      check("rst_drop_read", readResult, 32'h0);
      writeEnabled = 1'b0;
      #2;
      reset = 1'b1;
      model_clear();
      read_check("post_rst_a5", 32'd5);
      do_write(32'd3, 32'h0BADF00D);
      read_check("post_rst_wr_a3", 32'd3);
      written.push_back(32'd3);

      // Random soak: one operation per ten half-cycles
      for (int step = 0; step < 200; step += 10) begin
         op_is_write = $urandom_range(0, 1);
         if (op_is_write != 0) begin
            raddr = $urandom_range(0, 1023);
            rval  = $urandom;
            do_write(raddr, rval);
            written.push_back(raddr);
            repeat (4) @(posedge clock);
         end else begin
            @(negedge clock);
            if ($urandom_range(0, 1) == 0 && written.size() > 0)
               raddr = written[$urandom_range(0, written.size() - 1)];
            else
               raddr = $urandom_range(0, 1023);
            read_check($sformatf("soak_rd_%0d", raddr), raddr);
            repeat (5) @(posedge clock);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
